tmds_encoder: RTL and testbench



---
 rtl/tmds_pkg.sv | 43 ++++
 rtl/tmds_channel_encoder.sv | 89 ++++++++
 rtl/tmds_encoder.sv | 57 +++++
 tb/tb_tmds_encoder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared constants and helpers for the DVI 1.0 TMDS encoder: symbol and disparity
// widths, the four control-period codes, and the stage-1 transition-minimising math.
package tmds_pkg;

    localparam int SYM_W  = 10;
    localparam int DISP_W = 5;

    localparam logic [SYM_W-1:0] CTRL_00 = 10'b1101010100;
    localparam logic [SYM_W-1:0] CTRL_01 = 10'b0010101011;
    localparam logic [SYM_W-1:0] CTRL_10 = 10'b0101010100;
    localparam logic [SYM_W-1:0] CTRL_11 = 10'b1010101011;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // XNOR chain when the byte is ones-heavy (or balanced with d[0]=0), XOR chain
    // otherwise; bit 8 records which chain was used (1 = XOR).
    function automatic logic [8:0] transition_min(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] qm;
        n1       = popcount8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && (d[0] == 1'b0));
        qm       = 9'd0;
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++) begin
            if (use_xnor) begin
                qm[i] = ~(qm[i-1] ^ d[i]);
            end else begin
                qm[i] = qm[i-1] ^ d[i];
            end
        end
        qm[8] = ~use_xnor;
        return qm;
    endfunction

endpackage

// File: rtl/tmds_channel_encoder.sv
// One TMDS lane: stage 1 transition minimisation, stage 2 DC balancing with its own
// running disparity counter, or a control code while data_enable is low.
module tmds_channel_encoder
    import tmds_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       d,
    input  logic             de,
    input  logic             c0,
    input  logic             c1,
    output logic [SYM_W-1:0] sym
);

    logic [8:0]               q_m_s;
    logic [8:0]               q_m_r;
    logic [3:0]               n1_r;
    logic                     de_r;
    logic [1:0]               ctrl_r;
    logic signed [DISP_W-1:0] diff_s;
    logic signed [DISP_W-1:0] cnt_s;
    logic signed [DISP_W-1:0] cnt_r;
    logic [SYM_W-1:0]         sym_s;
    logic [SYM_W-1:0]         sym_r;

    assign q_m_s = transition_min(d);

    // Stage 1 register: q_m, its ones count, and the DE/control alignment bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_m_r  <= 9'd0;
            n1_r   <= 4'd0;
            de_r   <= 1'b0;
            ctrl_r <= 2'b00;
        end else begin
            q_m_r  <= q_m_s;
            n1_r   <= popcount8(q_m_s[7:0]);
            de_r   <= de;
            ctrl_r <= {c1, c0};
        end
    end

    // N1 - N0 of q_m[7:0], range -8..+8
    assign diff_s = $signed({1'b0, n1_r}) - $signed(5'd8 - {1'b0, n1_r});

    // Stage 2 decode: symbol selection and next running disparity
    always_comb begin
        sym_s = CTRL_00;
        cnt_s = cnt_r;
        if (!de_r) begin
            cnt_s = 5'sd0;
            case (ctrl_r)
                2'b00:   sym_s = CTRL_00;
                2'b01:   sym_s = CTRL_01;
                2'b10:   sym_s = CTRL_10;
                2'b11:   sym_s = CTRL_11;
                default: sym_s = CTRL_00;
            endcase
        end else if ((cnt_r == 5'sd0) || (diff_s == 5'sd0)) begin
            sym_s = {~q_m_r[8], q_m_r[8], (q_m_r[8] ? q_m_r[7:0] : ~q_m_r[7:0])};
            if (q_m_r[8]) begin
                cnt_s = cnt_r + diff_s;
            end else begin
                cnt_s = cnt_r - diff_s;
            end
        end else if (((cnt_r > 5'sd0) && (diff_s > 5'sd0)) ||
                     ((cnt_r < 5'sd0) && (diff_s < 5'sd0))) begin
            sym_s = {1'b1, q_m_r[8], ~q_m_r[7:0]};
            cnt_s = cnt_r + $signed({3'b000, q_m_r[8], 1'b0}) - diff_s;
        end else begin
            sym_s = {1'b0, q_m_r[8], q_m_r[7:0]};
            cnt_s = cnt_r - $signed({3'b000, ~q_m_r[8], 1'b0}) + diff_s;
        end
    end

    // Stage 2 register: output symbol and running disparity
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sym_r <= CTRL_00;
            cnt_r <= 5'sd0;
        end else begin
            sym_r <= sym_s;
            cnt_r <= cnt_s;
        end
    end

    assign sym = sym_r;

endmodule

// File: rtl/tmds_encoder.sv
// Three-lane DVI TMDS encoder. Routes colour data to lanes (optionally swapping
// red/blue); sync always rides on lane 0, lanes 1 and 2 carry control code 00.
module tmds_encoder
    import tmds_pkg::*;
#(
    parameter bit SWAP_RB = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       data_red,
    input  logic [7:0]       data_green,
    input  logic [7:0]       data_blue,
    input  logic             data_enable,
    input  logic             hSync,
    input  logic             vSync,
    output logic [SYM_W-1:0] tmds_ch0,
    output logic [SYM_W-1:0] tmds_ch1,
    output logic [SYM_W-1:0] tmds_ch2
);

    logic [7:0] ch0_data_s;
    logic [7:0] ch2_data_s;

    assign ch0_data_s = SWAP_RB ? data_red  : data_blue;
    assign ch2_data_s = SWAP_RB ? data_blue : data_red;

    tmds_channel_encoder u_ch0 (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (ch0_data_s),
        .de      (data_enable),
        .c0      (hSync),
        .c1      (vSync),
        .sym     (tmds_ch0)
    );

    tmds_channel_encoder u_ch1 (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (data_green),
        .de      (data_enable),
        .c0      (1'b0),
        .c1      (1'b0),
        .sym     (tmds_ch1)
    );

    tmds_channel_encoder u_ch2 (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (ch2_data_s),
        .de      (data_enable),
        .c0      (1'b0),
        .c1      (1'b0),
        .sym     (tmds_ch2)
    );

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: directed control/data cases, async reset,
// then random pixels against an integer reference model with a two-cycle lag.
module tb_tmds_encoder;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] data_red = 8'd0;
    logic [7:0] data_green = 8'd0;
    logic [7:0] data_blue = 8'd0;
    logic       data_enable = 1'b0;
    logic       hSync = 1'b0;
    logic       vSync = 1'b0;
    logic [9:0] tmds_ch0;
    logic [9:0] tmds_ch1;
    logic [9:0] tmds_ch2;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [2:0][9:0] s;
        logic [2:0][7:0] d;
        int              k0;
        int              k1;
        int              k2;
        logic            de;
        logic [1:0]      c;
        logic            lv;
        int              lch;
        logic [9:0]      lsym;
        int              lk;
    } exp_t;

    exp_t q[$];
    int   mcnt[3];

    tmds_encoder #(.SWAP_RB(1'b0)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .data_red    (data_red),
        .data_green  (data_green),
        .data_blue   (data_blue),
        .data_enable (data_enable),
        .hSync       (hSync),
        .vSync       (vSync),
        .tmds_ch0    (tmds_ch0),
        .tmds_ch1    (tmds_ch1),
        .tmds_ch2    (tmds_ch2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference encoder written directly from the DVI rules with integer counts.
    function automatic logic [9:0] enc(input logic [7:0] d, input logic de, input logic [1:0] c,
                                       input int cin, output int cout);
        int         n1;
        int         ones;
        int         zeros;
        logic       xn;
        logic [8:0] qm;
        logic [9:0] s;
        cout = cin;
        if (!de) begin
            cout = 0;
            case (c)
                2'b00:   s = 10'b1101010100;
                2'b01:   s = 10'b0010101011;
                2'b10:   s = 10'b0101010100;
                default: s = 10'b1010101011;
            endcase
            return s;
        end
        n1 = $countones(d);
        xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm = 9'd0;
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~xn;
        ones  = $countones(qm[7:0]);
        zeros = 8 - ones;
        if (cin == 0 || ones == zeros) begin
            s    = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            cout = qm[8] ? cin + ones - zeros : cin + zeros - ones;
        end else if ((cin > 0 && ones > zeros) || (cin < 0 && zeros > ones)) begin
            s    = {1'b1, qm[8], ~qm[7:0]};
            cout = cin + 2 * int'(qm[8]) + zeros - ones;
        end else begin
            s    = {1'b0, qm[8], qm[7:0]};
            cout = cin - 2 * (qm[8] ? 0 : 1) + ones - zeros;
        end
        return s;
    endfunction

    function automatic logic [7:0] dec(input logic [9:0] s);
        logic [7:0] t;
        logic [7:0] r;
        t    = s[9] ? ~s[7:0] : s[7:0];
        r    = 8'd0;
        r[0] = t[0];
        for (int i = 1; i < 8; i++) r[i] = s[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
        return r;
    endfunction

    function automatic logic [3:0] cdec(input logic [9:0] s);
        case (s)
            10'b1101010100: return 4'd0;
            10'b0010101011: return 4'd1;
            10'b0101010100: return 4'd2;
            10'b1010101011: return 4'd3;
            default:        return 4'hf;
        endcase
    endfunction

    task automatic compare(input exp_t e);
        logic [2:0][9:0] o;
        int              dk[3];
        int              ek[3];
        o     = {tmds_ch2, tmds_ch1, tmds_ch0};
        dk[0] = int'($signed(dut.u_ch0.cnt_r));
        dk[1] = int'($signed(dut.u_ch1.cnt_r));
        dk[2] = int'($signed(dut.u_ch2.cnt_r));
        ek[0] = e.k0;
        ek[1] = e.k1;
        ek[2] = e.k2;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("sym_ch%0d", i), 32'(o[i]), 32'(e.s[i]));
            chk($sformatf("cnt_ch%0d", i), dk[i], ek[i]);
            chk($sformatf("cnt_range_ch%0d", i), 32'(dk[i] >= -16 && dk[i] <= 15), 32'd1);
            if (e.de) begin
                chk($sformatf("decode_ch%0d", i), 32'(dec(o[i])), 32'(e.d[i]));
            end else begin
                chk($sformatf("ctrl_ch%0d", i), 32'(cdec(o[i])), (i == 0) ? 32'(e.c) : 32'd0);
            end
        end
        if (e.lv) begin
            chk("directed_sym", 32'(o[e.lch]), 32'(e.lsym));
            chk("directed_cnt", dk[e.lch], e.lk);
        end
    endtask

    task automatic drive(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic de, input logic hs, input logic vs,
                         input logic lv, input int lch, input logic [9:0] lsym, input int lk);
        exp_t e;
        int   nk;
        @(negedge clk);
        if (q.size() >= 2) compare(q.pop_front());
        data_red    = r;
        data_green  = g;
        data_blue   = b;
        data_enable = de;
        hSync       = hs;
        vSync       = vs;
        e.d    = {r, g, b};
        e.de   = de;
        e.c    = {vs, hs};
        e.s[0] = enc(b, de, {vs, hs}, mcnt[0], nk); mcnt[0] = nk; e.k0 = nk;
        e.s[1] = enc(g, de, 2'b00,    mcnt[1], nk); mcnt[1] = nk; e.k1 = nk;
        e.s[2] = enc(r, de, 2'b00,    mcnt[2], nk); mcnt[2] = nk; e.k2 = nk;
        e.lv   = lv;
        e.lch  = lch;
        e.lsym = lsym;
        e.lk   = lk;
        q.push_back(e);
    endtask

    task automatic px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic de, input logic hs, input logic vs);
        drive(r, g, b, de, hs, vs, 1'b0, 0, 10'd0, 0);
    endtask

    task automatic do_reset(input int hold);
        exp_t idle;
        @(posedge clk);
        #2;
        reset_n     = 1'b0;
        data_enable = 1'b0;
        hSync       = 1'b0;
        vSync       = 1'b0;
        #1;
        chk("rst_async_ch0", 32'(tmds_ch0), 32'h354);
        chk("rst_async_ch1", 32'(tmds_ch1), 32'h354);
        chk("rst_async_ch2", 32'(tmds_ch2), 32'h354);
        repeat (hold) begin
            @(negedge clk);
            chk("rst_hold", 32'({tmds_ch2, tmds_ch1, tmds_ch0}), 32'({3{10'b1101010100}}));
        end
        reset_n = 1'b1;
        q.delete();
        idle.s   = {3{10'b1101010100}};
        idle.d   = '0;
        idle.k0  = 0;
        idle.k1  = 0;
        idle.k2  = 0;
        idle.de  = 1'b0;
        idle.c   = 2'b00;
        idle.lv  = 1'b0;
        idle.lch = 0;
        idle.lsym = 10'd0;
        idle.lk  = 0;
        q.push_back(idle);
        q.push_back(idle);
        for (int i = 0; i < 3; i++) mcnt[i] = 0;
    endtask

    initial begin
        do_reset(4);
        repeat (3) px(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        // Control periods on lane 0
        drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 0, 10'b0010101011, 0);
        drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 0, 10'b1010101011, 0);
        px(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        // Blue 0x00 run from cnt=0
        drive(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 0, 10'b0100000000, -8);
        drive(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 0, 10'b1111111111, 2);
        drive(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 0, 10'b0100000000, -6);
        px(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        // Green 0xFF from cnt=0
        drive(8'h00, 8'hff, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1, 10'b1000000000, -8);

        // Disparity left non-zero, one blanking cycle, then restart from zero
        px(8'h00, 8'h13, 8'h00, 1'b1, 1'b0, 1'b0);
        px(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 0, 10'b0100000000, -8);

        // Random traffic with an asynchronous reset mid-line
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) do_reset(2);
            px(8'($urandom), 8'($urandom), 8'($urandom),
               1'($urandom_range(0, 9) < 8), 1'($urandom), 1'($urandom));
        end
        repeat (2) px(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
